load_store_unit: RTL and testbench
==================================

# load_store_unit

Pipeline-side initiator for data memory accesses. Accepts one load or store per request from the execute stage, sequences it as 1, 2 or 4 byte transactions on a byte-wide synchronous-read memory port, and returns sign- or zero-extended load data with a completion pulse. Sits between the CPU datapath (MemRead/MemWrite/func3 from control) and the byte-addressed data memory.

## Interface
- ADDR_W, 6, byte address width; addresses wrap modulo 2^ADDR_W
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  LSU idle and able to accept; a request is accepted at a rising edge with req_valid & req_ready
- MemRead  in  1  load request
- MemWrite  in  1  store request
- func3  in  3  access type: 000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only)
- addr  in  ADDR_W  start byte address (any alignment)
- data_in  in  32  store data (rs2), little-endian byte k = bits [8k+7:8k]
- data_out  out  32  last completed load result, extended to 32 bits
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done for a rejected request
- mem_addr  out  ADDR_W  byte address to memory
- mem_re  out  1  byte read strobe
- mem_we  out  1  byte write strobe
- mem_wdata  out  8  byte write data
- mem_rdata  in  8  read byte, valid the cycle after the mem_re cycle

## Operation
- States: IDLE, XFER, DRAIN, DONE. req_ready = 1 only in IDLE.
- On accept, register MemRead, MemWrite, func3, addr, data_in; inputs ignored at all other times. n = 1 (B/BU), 2 (H/HU), 4 (W).
- Illegal request: MemRead == MemWrite, func3 in {011,110,111}, or store with func3[2]=1. IDLE -> DONE directly; done=err=1; no mem strobes; data_out unchanged.
- XFER: byte counter k = 0..n-1, one byte per cycle; mem_addr = addr + k (ADDR_W-bit wrap, e.g. 0x3F + 1 = 0x00); store drives mem_we=1, mem_wdata = data_in byte k; load drives mem_re=1.
- Load: mem_rdata captured into byte k of an assembly register in the cycle after byte k is issued; after k = n-1, go to DRAIN to capture the last byte, then DONE.
- Store: after k = n-1, XFER -> DONE.
- DONE: done=1 for one cycle; for loads data_out is updated in the same cycle: B sign-extends bit 7, H sign-extends bit 15, BU/HU zero-extend, W unmodified. Stores never change data_out. DONE -> IDLE.
- mem_re, mem_we are never both 1; both 0 outside XFER.

## Timing
- Accept edge = T0. XFER occupies cycles T1..Tn.
- Store: done in T(n+1); req_ready high again T(n+2). SW = 5-cycle done latency.
- Load: DRAIN in T(n+1), done + new data_out in T(n+2), req_ready high T(n+3). LW = 6 cycles.
- Illegal: done/err in T1, req_ready high T2.
- Reset values: req_ready=1, data_out=0, done=0, err=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, state IDLE, counter 0.
- rst asserted mid-operation: outputs go to reset values immediately; no done pulse; bytes of a store already written stay written; partial load result discarded.
- req_valid held high across done: the next request is accepted at the first edge with req_ready=1 (no back-to-back in DONE).

## Test plan
- Reset: assert rst mid-LW -> mem_re drops same cycle, data_out=0, req_ready=1, no done.
- SW addr 0x10 data_in 0xDEADBEEF -> mem_we at 0x10..0x13 with EF,BE,AD,DE in T1..T4; done T5; then LW 0x10 -> data_out 0xDEADBEEF with done at T6.
- Memory 0x20=0x80: LB -> data_out 0xFFFFFF80; LBU -> 0x00000080; memory 0x21..0x22 = 0x34,0xF2: LH 0x21 -> 0xFFFFF234, LHU -> 0x0000F234.
- Wrap: SH addr 0x3F data 0x00001234 -> writes 0x34 @0x3F, 0x12 @0x00; LHU 0x3F -> 0x00001234.
- Illegal: MemRead=MemWrite=1, or store func3=100 -> done=err=1 in T1, no mem strobes, data_out unchanged.
- Handshake: req_valid pulsed while busy is ignored; req_valid held high issues two back-to-back SBs exactly n+2 cycles apart.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store sequencer: splits B/H/W accesses into byte transactions on a
// synchronous-read byte memory and returns extended load data with a done pulse.
module load_store_unit #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        func3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       dout_q, dout_d;

  logic       illegal_req;
  logic [1:0] last_idx;
  logic       cap_en;
  logic [1:0] cap_idx;
  logic [31:0] ext_val;

  always_comb begin
    illegal_req = (MemRead == MemWrite) ||
                  (func3 == 3'b011) || (func3 == 3'b110) || (func3 == 3'b111) ||
                  (MemWrite && func3[2]);

    case (f3_q[1:0])
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase

    // Read data lags the strobe by one cycle: XFER captures the previous byte,
    // DRAIN captures the final one (counter is held at n-1 there).
    cap_en  = 1'b0;
    cap_idx = cnt_q;
    if (state_q == XFER && rd_q && cnt_q != 2'd0) begin
      cap_en  = 1'b1;
      cap_idx = cnt_q - 2'd1;
    end else if (state_q == DRAIN) begin
      cap_en  = 1'b1;
      cap_idx = cnt_q;
    end

    asm_d = asm_q;
    if (cap_en) asm_d[{cap_idx, 3'b000} +: 8] = mem_rdata;

    case (f3_q)
      3'b000:  ext_val = {{24{asm_d[7]}}, asm_d[7:0]};
      3'b001:  ext_val = {{16{asm_d[15]}}, asm_d[15:0]};
      3'b100:  ext_val = {24'd0, asm_d[7:0]};
      3'b101:  ext_val = {16'd0, asm_d[15:0]};
      default: ext_val = asm_d;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = err_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rd_d    = MemRead;
          wr_d    = MemWrite;
          f3_d    = func3;
          addr_d  = addr;
          wdata_d = data_in;
          err_d   = illegal_req;
          cnt_d   = '0;
          state_d = illegal_req ? DONE : XFER;
        end
      end
      XFER: begin
        if (cnt_q == last_idx) state_d = rd_q ? DRAIN : DONE;
        else                   cnt_d   = cnt_q + 2'd1;
      end
      DRAIN: begin
        dout_d  = ext_val;
        state_d = DONE;
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      asm_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      asm_q   <= asm_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    done      = (state_q == DONE);
    err       = (state_q == DONE) && err_q;
    mem_re    = (state_q == XFER) && rd_q;
    mem_we    = (state_q == XFER) && wr_q;
    mem_addr  = (state_q == XFER) ? addr_q + ADDR_W'(cnt_q) : '0;
    mem_wdata = mem_we ? wdata_q[{cnt_q, 3'b000} +: 8] : '0;
    data_out  = dout_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-array reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        MemRead, MemWrite;
  logic [2:0]  func3;
  logic [5:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        done, err;
  logic [5:0]  mem_addr;
  logic        mem_re, mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  tb_mem  [64];
  logic [7:0]  ref_mem [64];
  logic [31:0] exp_dout;
  int unsigned errs = 0;
  int unsigned checks = 0;

  load_store_unit #(.ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .func3(func3), .addr(addr),
    .data_in(data_in), .data_out(data_out), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= tb_mem[mem_addr];
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic wait_ready();
    int unsigned to = 0;
    @(negedge clk);
    while (!req_ready && to < 50) begin
      @(negedge clk);
      to++;
    end
    check_eq("ready", {63'd0, req_ready}, 64'd1);
  endtask

  // Drive one request and check every cycle up to and including done,
  // then the idle cycle after it.
  task automatic do_req(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [5:0] a, input logic [31:0] d, input bit poke);
    int unsigned n, lat;
    bit          ill;
    longint      v;
    logic [31:0] newd;
    logic        e_re, e_we;
    logic [5:0]  e_addr;
    logic [7:0]  e_wd;
    logic [31:0] e_dout;

    ill = (rd == wr) || (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (wr && f3[2]);
    n   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    lat = ill ? 1 : (wr ? n + 1 : n + 2);

    newd = exp_dout;
    if (!ill && rd) begin
      v = 0;
      for (int i = 0; i < int'(n); i++)
        v += longint'(ref_mem[(int'(a) + i) % 64]) << (8 * i);
      if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
        v -= longint'(1) << (8 * n);
      newd = v[31:0];
    end

    wait_ready();
    req_valid = 1'b1; MemRead = rd; MemWrite = wr; func3 = f3; addr = a; data_in = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    MemRead = 1'($urandom); MemWrite = 1'($urandom); func3 = 3'($urandom);
    addr = 6'($urandom); data_in = $urandom;

    for (int t = 1; t <= int'(lat); t++) begin
      @(negedge clk);
      e_re   = !ill && rd && t <= int'(n);
      e_we   = !ill && wr && t <= int'(n);
      e_addr = (e_re || e_we) ? 6'((int'(a) + t - 1) % 64) : 6'd0;
      e_wd   = e_we ? d[8 * (t - 1) +: 8] : 8'd0;
      e_dout = (t == int'(lat)) ? newd : exp_dout;
      check_eq("cycle", {req_ready, done, err, mem_re, mem_we, mem_addr, mem_wdata, data_out},
               {1'b0, t == int'(lat), ill && t == int'(lat), e_re, e_we, e_addr, e_wd, e_dout});
      if (poke && !ill && t == 1) begin
        req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; func3 = 3'b010;
        addr = 6'($urandom); data_in = $urandom;
      end
      if (poke && t == 2) req_valid = 1'b0;
    end
    req_valid = 1'b0;

    if (!ill && wr)
      for (int i = 0; i < int'(n); i++) ref_mem[(int'(a) + i) % 64] = d[8 * i +: 8];
    exp_dout = newd;

    @(negedge clk);
    check_eq("post", {done, err, req_ready, data_out}, {1'b0, 1'b0, 1'b1, exp_dout});
  endtask

  initial begin
    int unsigned d1, d2, bad, seen;
    bit r, w;

    for (int i = 0; i < 64; i++) begin
      tb_mem[i]  = 8'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    req_valid = 0; MemRead = 0; MemWrite = 0; func3 = 0; addr = 0; data_in = 0;
    exp_dout = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset", {req_ready, done, err, mem_re, mem_we, mem_addr, mem_wdata, data_out},
             {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 8'd0, 32'd0});
    rst = 1'b0;

    do_req(0, 1, 3'b010, 6'h10, 32'hDEADBEEF, 0);
    check_eq("sw_bytes", {tb_mem[16'h13], tb_mem[16'h12], tb_mem[16'h11], tb_mem[16'h10]}, 64'hDEADBEEF);
    do_req(1, 0, 3'b010, 6'h10, 32'h0, 0);
    check_eq("lw", data_out, 64'hDEADBEEF);

    // Asynchronous reset in the middle of a word load.
    wait_ready();
    req_valid = 1; MemRead = 1; MemWrite = 0; func3 = 3'b010; addr = 6'h10;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    check_eq("pre_rst_re", {63'd0, mem_re}, 64'd1);
    #2 rst = 1'b1;
    #1 check_eq("rst_mid", {mem_re, mem_we, done, err, req_ready, mem_addr, data_out},
                {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 32'd0});
    @(negedge clk);
    rst = 1'b0;
    exp_dout = 0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen++;
    end
    check_eq("rst_no_done", seen, 0);

    do_req(0, 1, 3'b000, 6'h20, 32'h80, 0);
    do_req(1, 0, 3'b000, 6'h20, 32'h0, 0);
    check_eq("lb", data_out, 64'hFFFFFF80);
    do_req(1, 0, 3'b100, 6'h20, 32'h0, 0);
    check_eq("lbu", data_out, 64'h00000080);
    do_req(0, 1, 3'b000, 6'h21, 32'h34, 0);
    do_req(0, 1, 3'b000, 6'h22, 32'hF2, 0);
    do_req(1, 0, 3'b001, 6'h21, 32'h0, 0);
    check_eq("lh", data_out, 64'hFFFFF234);
    do_req(1, 0, 3'b101, 6'h21, 32'h0, 0);
    check_eq("lhu", data_out, 64'h0000F234);

    do_req(0, 1, 3'b001, 6'h3F, 32'h00001234, 0);
    check_eq("wrap_bytes", {tb_mem[0], tb_mem[63]}, 64'h1234);
    do_req(1, 0, 3'b101, 6'h3F, 32'h0, 0);
    check_eq("wrap_lhu", data_out, 64'h00001234);

    do_req(1, 1, 3'b010, 6'h08, 32'h11223344, 0);
    do_req(0, 0, 3'b000, 6'h08, 32'h11223344, 0);
    do_req(0, 1, 3'b100, 6'h08, 32'h11223344, 0);
    do_req(1, 0, 3'b011, 6'h08, 32'h0, 0);
    check_eq("ill_keep", data_out, 64'h00001234);

    do_req(0, 1, 3'b010, 6'h30, 32'hA5A5_5A5A, 1);
    do_req(1, 0, 3'b010, 6'h30, 32'h0, 1);

    // req_valid held high: two SBs, done pulses exactly 3 cycles apart.
    wait_ready();
    req_valid = 1; MemRead = 0; MemWrite = 1; func3 = 3'b000; addr = 6'h05; data_in = 32'h5A;
    d1 = 0; d2 = 0; seen = 0;
    for (int c = 1; c <= 20 && seen < 2; c++) begin
      @(negedge clk);
      if (done) begin
        seen++;
        if (seen == 1) d1 = c;
        else begin
          d2 = c;
          req_valid = 0;
        end
      end
    end
    req_valid = 0;
    ref_mem[5] = 8'h5A;
    check_eq("b2b_count", seen, 2);
    check_eq("b2b_gap", d2 - d1, 3);

    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        r = 1'($urandom); w = r;
      end else begin
        r = 1'($urandom); w = !r;
      end
      do_req(r, w, 3'($urandom), 6'($urandom), $urandom, ($urandom_range(0, 3) == 0));
    end

    bad = 0;
    for (int i = 0; i < 64; i++) if (tb_mem[i] !== ref_mem[i]) bad++;
    check_eq("mem_image", bad, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  always @(negedge clk) begin
    if (mem_re && mem_we) begin
      errs++;
      $display("FAIL strobe_excl: got re=%b we=%b expected not both", mem_re, mem_we);
    end
  end

endmodule
